// File: rtl/byte_bank_arbiter_pkg.sv
// Shared defaults and round-robin port indices for the byte bank arbiter.
package byte_bank_arbiter_pkg;

   localparam int WIDTH_DEF  = 8;
   localparam int ADDR_W_DEF = 2;

   localparam logic P0 = 1'b0;
   localparam logic P1 = 1'b1;

endpackage

// File: rtl/byte_bank_arbiter_en_reg.sv
// Enable-DFF register used for every entry of the byte bank.
module en_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= '0;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/byte_bank_arbiter_rr_arb2.sv
// Pure combinational 2-way round-robin selector; sel names the winning port.
module rr_arb2
   import byte_bank_arbiter_pkg::*;
(
   input  logic elig0,
   input  logic elig1,
   input  logic last,
   output logic sel,
   output logic valid
);

   // On contention the port that did not win last time takes the slot.
   always_comb begin
      valid = elig0 | elig1;
      if (elig0 && elig1)
         sel = (last == P0) ? P1 : P0;
      else if (elig1)
         sel = P1;
      else
         sel = P0;
   end

endmodule

// File: rtl/byte_bank_arbiter.sv
// Two-port round-robin arbiter in front of a bank of byte registers;
// each grant performs one single-cycle read or write.
module byte_bank_arbiter
   import byte_bank_arbiter_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [WIDTH-1:0]  wdata0,
   output logic              gnt0,
   output logic [WIDTH-1:0]  rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [WIDTH-1:0]  wdata1,
   output logic              gnt1,
   output logic [WIDTH-1:0]  rdata1
);

   localparam int DEPTH = 1 << ADDR_W;

   logic              last;
   logic              elig0;
   logic              elig1;
   logic              sel;
   logic              valid;
   logic              win_we;
   logic [ADDR_W-1:0] win_addr;
   logic [WIDTH-1:0]  win_wdata;
   logic [WIDTH-1:0]  rd_val;
   logic [DEPTH-1:0]  bank_en;
   logic [WIDTH-1:0]  bank_q [DEPTH];

   // A port is masked during its own grant cycle so a held req cannot reissue.
   assign elig0 = req0 & ~gnt0;
   assign elig1 = req1 & ~gnt1;

   rr_arb2 u_arb (
      .elig0 (elig0),
      .elig1 (elig1),
      .last  (last),
      .sel   (sel),
      .valid (valid)
   );

   assign win_we    = (sel == P1) ? we1    : we0;
   assign win_addr  = (sel == P1) ? addr1  : addr0;
   assign win_wdata = (sel == P1) ? wdata1 : wdata0;
   assign rd_val    = bank_q[win_addr];

   for (genvar i = 0; i < DEPTH; i++) begin : gen_bank
      assign bank_en[i] = valid & win_we & (win_addr == ADDR_W'(i));

      en_reg #(.WIDTH(WIDTH)) u_reg (
         .clk (clk),
         .rst (rst),
         .en  (bank_en[i]),
         .d   (win_wdata),
         .q   (bank_q[i])
      );
   end

   // Grant pulses, round-robin pointer and per-port read data capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt0   <= 1'b0;
         gnt1   <= 1'b0;
         last   <= P1;
         rdata0 <= '0;
         rdata1 <= '0;
      end else begin
         gnt0 <= valid & (sel == P0);
         gnt1 <= valid & (sel == P1);
         if (valid) begin
            last <= sel;
            if (!win_we) begin
               if (sel == P1)
                  rdata1 <= rd_val;
               else
                  rdata0 <= rd_val;
            end
         end
      end
   end

endmodule

// File: tb/tb_byte_bank_arbiter.sv
// Scoreboard bench for byte_bank_arbiter: a cycle model pushes expected
// outputs per driven cycle, which are popped after the following edge.
module tb_byte_bank_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0 = 0, we0 = 0, req1 = 0, we1 = 0;
   logic [1:0] addr0 = 0, addr1 = 0;
   logic [7:0] wdata0 = 0, wdata1 = 0;
   logic       gnt0, gnt1;
   logic [7:0] rdata0, rdata1;

   typedef struct {
      logic       g0;
      logic       g1;
      logic [7:0] r0;
      logic [7:0] r1;
   } exp_t;

   exp_t       sb[$];
   int         tests = 0;
   int         fails = 0;
   logic       prev_g0 = 0;
   logic       prev_g1 = 0;

   logic       m_g0, m_g1, m_last;
   logic [7:0] m_r0, m_r1;
   logic [7:0] m_regs [4];

   always #5 clk = ~clk;

   byte_bank_arbiter dut (
      .clk    (clk),
      .rst    (rst),
      .req0   (req0),
      .we0    (we0),
      .addr0  (addr0),
      .wdata0 (wdata0),
      .gnt0   (gnt0),
      .rdata0 (rdata0),
      .req1   (req1),
      .we1    (we1),
      .addr1  (addr1),
      .wdata1 (wdata1),
      .gnt1   (gnt1),
      .rdata1 (rdata1)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic modelReset();
      m_g0 = 0; m_g1 = 0; m_last = 1; m_r0 = 0; m_r1 = 0;
      for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
      sb.delete();
      prev_g0 = 0; prev_g1 = 0;
   endtask

   // Compare the outputs produced by the previous edge against the scoreboard.
   task automatic popCheck();
      exp_t e;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         checkOutput("gnt0", {31'b0, gnt0}, {31'b0, e.g0});
         checkOutput("gnt1", {31'b0, gnt1}, {31'b0, e.g1});
         checkOutput("rdata0", {24'b0, rdata0}, {24'b0, e.r0});
         checkOutput("rdata1", {24'b0, rdata1}, {24'b0, e.r1});
         checkOutput("gnt_onehot", {31'b0, gnt0 & gnt1}, 32'd0);
         checkOutput("gnt0_consec", {31'b0, gnt0 & prev_g0}, 32'd0);
         checkOutput("gnt1_consec", {31'b0, gnt1 & prev_g1}, 32'd0);
         prev_g0 = gnt0;
         prev_g1 = gnt1;
      end
   endtask

   task automatic applyStimulus(input logic r0, input logic w0, input logic [1:0] a0, input logic [7:0] d0,
                                input logic r1, input logic w1, input logic [1:0] a1, input logic [7:0] d1);
      logic e0, e1, take0, take1;
      exp_t e;
      @(negedge clk);
      popCheck();
      req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
      e0 = r0 && !m_g0;
      e1 = r1 && !m_g1;
      take0 = e0 && (!e1 || m_last == 1'b1);
      take1 = e1 && !take0;
      if (take0) begin
         if (w0) m_regs[a0] = d0; else m_r0 = m_regs[a0];
         m_last = 1'b0;
      end else if (take1) begin
         if (w1) m_regs[a1] = d1; else m_r1 = m_regs[a1];
         m_last = 1'b1;
      end
      m_g0 = take0;
      m_g1 = take1;
      e.g0 = m_g0; e.g1 = m_g1; e.r0 = m_r0; e.r1 = m_r1;
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 2'd0, 8'h00, 0, 0, 2'd0, 8'h00);
   endtask

   initial begin
      modelReset();
      #12;
      checkOutput("rst_gnt0", {31'b0, gnt0}, 32'd0);
      checkOutput("rst_gnt1", {31'b0, gnt1}, 32'd0);
      checkOutput("rst_rdata0", {24'b0, rdata0}, 32'd0);
      checkOutput("rst_rdata1", {24'b0, rdata1}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Single uncontended read of a reset register.
      applyStimulus(1, 0, 2'd2, 8'h00, 0, 0, 2'd0, 8'h00);
      idle(1);

      // Write then read back through port 0, plus untouched registers.
      applyStimulus(1, 1, 2'd1, 8'hA5, 0, 0, 2'd0, 8'h00);
      idle(1);
      applyStimulus(1, 0, 2'd1, 8'h00, 0, 0, 2'd0, 8'h00);
      idle(1);
      checkOutput("rd_a5", {24'b0, rdata0}, 32'h0000_00A5);
      checkOutput("rd_a5_gnt", {31'b0, gnt0}, 32'd1);
      for (int a = 0; a < 4; a++) begin
         if (a != 1) begin
            applyStimulus(1, 0, 2'(a), 8'h00, 0, 0, 2'd0, 8'h00);
            idle(1);
         end
      end

      // Continuous contention: grants must alternate.
      for (int i = 0; i < 8; i++)
         applyStimulus(1, 0, 2'(i), 8'h00, 1, 0, 2'(i + 1), 8'h00);
      idle(2);

      // Same-address write race, then read it back from port 1.
      applyStimulus(1, 1, 2'd3, 8'h11, 1, 1, 2'd3, 8'h22);
      applyStimulus(0, 0, 2'd0, 8'h00, 1, 1, 2'd3, 8'h22);
      idle(1);
      applyStimulus(0, 0, 2'd0, 8'h00, 1, 0, 2'd3, 8'h00);
      idle(1);
      checkOutput("race_rd", {24'b0, rdata1}, 32'h0000_0022);

      // Port 0 held alone: grant every other cycle.
      for (int i = 0; i < 6; i++)
         applyStimulus(1, 0, 2'd3, 8'h00, 0, 0, 2'd0, 8'h00);
      idle(2);

      // Asynchronous reset while a write grant is up and port 1 is pending.
      applyStimulus(1, 1, 2'd0, 8'h5A, 0, 0, 2'd0, 8'h00);
      applyStimulus(0, 0, 2'd0, 8'h00, 1, 0, 2'd0, 8'h00);
      #2;
      checkOutput("pre_rst_gnt0", {31'b0, gnt0}, 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("async_gnt0", {31'b0, gnt0}, 32'd0);
      checkOutput("async_gnt1", {31'b0, gnt1}, 32'd0);
      checkOutput("async_rdata0", {24'b0, rdata0}, 32'd0);
      checkOutput("async_rdata1", {24'b0, rdata1}, 32'd0);
      req0 = 0; req1 = 0;
      modelReset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // After reset: contention on addr 0, port 0 wins first and sees 00.
      applyStimulus(1, 0, 2'd0, 8'h00, 1, 0, 2'd0, 8'h00);
      idle(1);
      checkOutput("post_rst_gnt0", {31'b0, gnt0}, 32'd1);
      checkOutput("post_rst_rd", {24'b0, rdata0}, 32'd0);
      applyStimulus(0, 0, 2'd0, 8'h00, 1, 0, 2'd0, 8'h00);
      idle(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/byte_bank_arbiter.md
Name: byte_bank_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of a small bank of write-enabled byte registers.
- Two independent requesters, e.g. a CPU-side port and a DMA-side port, share one register bank through this block.
- Each granted access is one read or one write of one register, completed in one clock.
- The block holds the bank itself. Writes reach a register only through its write enable, and at most one register is enabled per cycle.

Parameters:
- WIDTH, 8: data width of each register.
- ADDR_W, 2: address width. DEPTH = 2**ADDR_W registers, 4 by default.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous reset, active-high.
- req0  input  1  requester 0 access request; held until gnt0.
- we0  input  1  requester 0: 1 = write, 0 = read.
- addr0  input  ADDR_W  requester 0 register index.
- wdata0  input  WIDTH  requester 0 write data.
- gnt0  output  1  one-cycle pulse: requester 0 access completed.
- rdata0  output  WIDTH  requester 0 read data; valid while gnt0=1 after a read.
- req1, we1, addr1, wdata1, gnt1, rdata1: same as above, for requester 1.

Behaviour:
- Reset (asynchronous, immediate on rst=1):
  - gnt0 = gnt1 = 0; rdata0 = rdata1 = 0.
  - All DEPTH registers = 0.
  - Round-robin pointer last = 1, so requester 0 wins the first contention.
- Eligibility in cycle N:
  - elig0 = req0 & ~gnt0; elig1 = req1 & ~gnt1.
  - A request is consumed at the edge that raises its gnt. During the gnt cycle that port's req is masked, so a held req cannot double-issue.
  - Consequence: one port alone gets at most one access per 2 cycles. The idle slot is available to the other port.
- Selection (combinational, cycle N):
  - Only one eligible: that port wins.
  - Both eligible: the port other than last wins.
  - None eligible: no access.
- Commit at edge N+1:
  - Winner's gnt = 1 for exactly one cycle; loser's gnt = 0.
  - last updates to the winner; unchanged when idle.
  - Write: reg[addr] <= wdata of the winner. Only that register's enable is asserted.
  - Read: winner's rdata <= reg[addr] value before the edge.
  - The losing port's rdata holds its previous value.
- Latency: request visible in cycle N gives gnt and data in cycle N+1 when uncontended. Worst case under contention: N+2.
- Simultaneous writes to the same address: only the winner's data lands. The loser is granted next eligible cycle and its write then overwrites.
- Read and write to the same address in different grants: the read returns the value committed by any earlier grant. There is no same-cycle forwarding, because only one access is performed per cycle.
- Fairness: with both ports requesting continuously, grants strictly alternate 0,1,0,1...
- Reset asserted mid-access: an access not yet granted is dropped. Any gnt in flight clears at once. The requester must re-request after rst falls.
- Inputs are sampled only in the cycle before the grant edge. addr/we/wdata may change freely after gnt.
- State machine: the only state is last plus the registered gnt0/gnt1. Valid gnt encodings are 00, 10, 01; gnt0 and gnt1 are never 1 together. This is a checkable invariant.

Decomposition:
- Shared header/package:
  - WIDTH and ADDR_W defaults.
  - Port-index constants P0 = 0, P1 = 1 for the last pointer.
- Sub-module rr_arb2: pure 2-way round-robin selector.
  - Inputs elig0, elig1, last.
  - Outputs sel and valid.
- Top level holds:
  - The gnt/last/rdata registers.
  - The address decode to one-hot write enables.
  - DEPTH instances of the team's existing enable-DFF byte register.
  - The read mux.

Test Plan:
- Reset, then req0=1, we0=0, addr0=2 → next cycle gnt0=1, rdata0=8'h00; gnt1 stays 0.
- req0 write addr0=1, wdata0=8'hA5; after gnt0, read addr0=1 → rdata0=8'hA5 with gnt0 on the read grant; registers 0, 2 and 3 remain 8'h00.
- req0 and req1 both held continuously with reads, starting from reset → gnt sequence 0,1,0,1 (gnt0 first); gnt0 and gnt1 never both high.
- Same cycle: req0 writes addr 3 = 8'h11 and req1 writes addr 3 = 8'h22 → gnt0 first, then gnt1; a final read of addr 3 returns 8'h22.
- req0 held alone continuously → gnt0 high every other cycle, never in two consecutive cycles.
- Write 8'h5A to addr 0, then assert rst asynchronously mid-cycle while req1 is pending → gnt0/gnt1/rdata go 0 immediately; after release, a read of addr 0 returns 8'h00 and requester 0 wins the first contention.
